// File: rtl/cpu_trace_buffer_pkg.sv
// Shared definitions for the CPU trace buffer: capture modes, FSM states,
// and the packed entry width.
package cpu_trace_buffer_pkg;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_INSTR  = 2'd1,
      MODE_BRANCH = 2'd2,
      MODE_TRIG   = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   // Entry layout, MSB first: {change_pc, state, pc, instruction}
   function automatic int entry_width(int pc_w, int instr_w, int state_w);
      return 1 + state_w + pc_w + instr_w;
   endfunction

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// Trace entry FIFO. A push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle; otherwise it is reported on o_drop.
module trace_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_valid,
   output logic [AW:0]      o_level,
   output logic             o_drop
);

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_pop;
   logic             w_push;

   assign w_pop  = i_pop && (r_level != '0);
   assign w_push = i_push && ((r_level != FULL_LEVEL) || w_pop);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // NOTE: storage is not reset; r_level alone decides which slots hold valid data.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_valid = (r_level != '0);
   assign o_level = r_level;
   assign o_drop  = i_push && !w_push;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trace capture buffer for the multi-cycle CPU: detects instruction/branch
// events on the debug taps, filters them by mode and PC trigger, and queues them.
module cpu_trace_buffer
   import cpu_trace_buffer_pkg::*;
#(
   parameter  int PC_W        = 16,
   parameter  int INSTR_W     = 32,
   parameter  int STATE_W     = 2,
   parameter  int FETCH_STATE = 0,
   parameter  int DEPTH       = 16,
   parameter  int CNT_W       = 8,
   parameter  int DROP_W      = 8,
   localparam int ENTRY_W     = entry_width(PC_W, INSTR_W, STATE_W),
   localparam int LVL_W       = $clog2(DEPTH) + 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_stop,
   input  logic [1:0]         i_mode,
   input  logic [PC_W-1:0]    i_trig_pc,
   input  logic [CNT_W-1:0]   i_post_count,
   input  logic [PC_W-1:0]    i_dbg_pc,
   input  logic [INSTR_W-1:0] i_dbg_instruction,
   input  logic [STATE_W-1:0] i_dbg_state,
   input  logic               i_dbg_change_pc,
   output logic               o_rd_valid,
   input  logic               i_rd_ready,
   output logic [ENTRY_W-1:0] o_rd_data,
   output logic [LVL_W-1:0]   o_level,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overflow,
   output logic [DROP_W-1:0]  o_drop_count
);

   localparam logic [STATE_W-1:0] FETCH = STATE_W'(FETCH_STATE);

   state_e             r_state;
   mode_e              r_mode;
   logic [PC_W-1:0]    r_trig_pc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic               r_done;
   logic               r_overflow;
   logic [DROP_W-1:0]  r_drop_count;
   logic [STATE_W-1:0] r_prev_state;
   logic               r_prev_change_pc;

   logic               w_instr_evt;
   logic               w_branch_evt;
   logic               w_push;
   logic               w_drop;
   logic [ENTRY_W-1:0] w_entry;

   assign w_instr_evt  = (i_dbg_state == FETCH) && (r_prev_state != FETCH);
   assign w_branch_evt = i_dbg_change_pc && !r_prev_change_pc;
   assign w_entry      = {i_dbg_change_pc, i_dbg_state, i_dbg_pc, i_dbg_instruction};

   // A stop wins over any event in the same cycle.
   // NOTE: default assignment first so no path through always_comb leaves w_push unassigned (no latch).
   always_comb begin
      w_push = 1'b0;
      case (r_state)
         ST_ARMED:   w_push = !i_stop && w_instr_evt && (i_dbg_pc == r_trig_pc);
         ST_CAPTURE: w_push = !i_stop && ((r_mode == MODE_BRANCH) ? w_branch_evt : w_instr_evt);
         default:    w_push = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state          <= ST_IDLE;
         r_mode           <= MODE_OFF;
         r_trig_pc        <= '0;
         r_cnt            <= '0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
         r_overflow       <= 1'b0;
         r_drop_count     <= '0;
         r_prev_state     <= '0;
         r_prev_change_pc <= 1'b0;
      end else begin
         r_prev_state     <= i_dbg_state;
         r_prev_change_pc <= i_dbg_change_pc;
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start && (mode_e'(i_mode) != MODE_OFF)) begin
                  r_mode       <= mode_e'(i_mode);
                  r_trig_pc    <= i_trig_pc;
                  r_cnt        <= i_post_count;
                  r_overflow   <= 1'b0;
                  r_drop_count <= '0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_state      <= (mode_e'(i_mode) == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
               end
            end
            ST_ARMED: begin
               if (i_stop || (w_push && (r_cnt == '0))) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_push) begin
                  r_state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (i_stop || (w_push && (r_mode == MODE_TRIG) && (r_cnt == CNT_W'(1)))) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
               // Post-trigger budget counts attempts, so dropped entries still consume it.
               if (w_push && (r_mode == MODE_TRIG)) r_cnt <= r_cnt - CNT_W'(1);
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_wdata (w_entry),
      .i_pop   (i_rd_ready),
      .o_rdata (o_rd_data),
      .o_valid (o_rd_valid),
      .o_level (o_level),
      .o_drop  (w_drop)
   );

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_overflow   = r_overflow;
   assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_cpu_trace_buffer;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 32;
   localparam int STATE_W = 2;
   localparam int DEPTH   = 16;
   localparam int CNT_W   = 8;
   localparam int DROP_W  = 8;
   localparam int ENTRY_W = 1 + STATE_W + PC_W + INSTR_W;
   localparam int LVL_W   = 5;
   localparam int PC_LSB  = INSTR_W;
   localparam int CP_BIT  = ENTRY_W - 1;

   logic               clk = 1'b0;
   logic               reset, start, stop, dbg_change_pc, rd_ready;
   logic [1:0]         mode, dbg_state;
   logic [PC_W-1:0]    trig_pc, dbg_pc;
   logic [CNT_W-1:0]   post_count;
   logic [INSTR_W-1:0] dbg_instr;
   logic               rd_valid, busy, done, overflow;
   logic [ENTRY_W-1:0] rd_data;
   logic [LVL_W-1:0]   level;
   logic [DROP_W-1:0]  drop_count;

   always #5 clk = ~clk;

   cpu_trace_buffer dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_start           (start),
      .i_stop            (stop),
      .i_mode            (mode),
      .i_trig_pc         (trig_pc),
      .i_post_count      (post_count),
      .i_dbg_pc          (dbg_pc),
      .i_dbg_instruction (dbg_instr),
      .i_dbg_state       (dbg_state),
      .i_dbg_change_pc   (dbg_change_pc),
      .o_rd_valid        (rd_valid),
      .i_rd_ready        (rd_ready),
      .o_rd_data         (rd_data),
      .o_level           (level),
      .o_busy            (busy),
      .o_done            (done),
      .o_overflow        (overflow),
      .o_drop_count      (drop_count)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 finished.
   logic [ENTRY_W-1:0] m_q[$];
   int                 m_phase = 0;
   int                 m_mode  = 0;
   int                 m_trig  = 0;
   int                 m_cnt   = 0;
   int                 m_drops = 0;
   bit                 m_ovf   = 0;
   int                 m_prev_state = 0;
   bit                 m_prev_cp    = 0;
   logic [PC_W-1:0]    popped_pc[$];
   bit                 popped_cp[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit ievt, bevt, want;
      if (!reset) begin
         m_q.delete();
         m_phase = 0; m_ovf = 0; m_drops = 0; m_prev_state = 0; m_prev_cp = 0;
         return;
      end
      ievt = (dbg_state == 2'd0) && (m_prev_state != 0);
      bevt = dbg_change_pc && !m_prev_cp;
      want = 0;
      case (m_phase)
         0, 3: if (start && mode != 2'd0) begin
            m_mode = int'(mode); m_trig = int'(trig_pc); m_cnt = int'(post_count);
            m_ovf = 0; m_drops = 0;
            m_phase = (mode == 2'd3) ? 1 : 2;
         end
         1: if (stop) m_phase = 3;
            else if (ievt && int'(dbg_pc) == m_trig) begin
               want = 1;
               m_phase = (m_cnt == 0) ? 3 : 2;
            end
         default: if (stop) m_phase = 3;
            else begin
               want = (m_mode == 2) ? bevt : ievt;
               if (want && m_mode == 3) begin
                  m_cnt--;
                  if (m_cnt == 0) m_phase = 3;
               end
            end
      endcase
      if (m_q.size() > 0 && rd_ready) void'(m_q.pop_front());
      if (want) begin
         if (m_q.size() < DEPTH) m_q.push_back({dbg_change_pc, dbg_state, dbg_pc, dbg_instr});
         else begin
            m_ovf = 1;
            if (m_drops < 255) m_drops++;
         end
      end
      m_prev_state = int'(dbg_state);
      m_prev_cp    = dbg_change_pc;
   endtask

   // One clock: record observed pops, advance the model, compare after the edge.
   task automatic tick();
      if (rd_valid && rd_ready) begin
         popped_pc.push_back(rd_data[PC_LSB +: PC_W]);
         popped_cp.push_back(rd_data[CP_BIT]);
      end
      model_step();
      @(posedge clk);
      #1;
      check("level", 64'(level), 64'(m_q.size()));
      check("rd_valid", 64'(rd_valid), 64'(m_q.size() > 0));
      check("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
      check("done", 64'(done), 64'(m_phase == 3));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_count", 64'(drop_count), 64'(m_drops));
      if (m_q.size() > 0) check("rd_data", 64'(rd_data), 64'(m_q[0]));
   endtask

   task automatic fetch(input logic [PC_W-1:0] pc);
      dbg_state = 2'd0; dbg_pc = pc; dbg_instr = $urandom;
      tick();
      dbg_state = 2'd1;
      tick();
   endtask

   task automatic do_start(input logic [1:0] m, input logic [PC_W-1:0] tp, input logic [CNT_W-1:0] pcnt);
      start = 1'b1; mode = m; trig_pc = tp; post_count = pcnt;
      tick();
      start = 1'b0; mode = 2'd0; trig_pc = '0; post_count = '0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; trig_pc = '0; post_count = '0;
      dbg_pc = '0; dbg_instr = '0; dbg_state = 2'd1; dbg_change_pc = 1'b0; rd_ready = 1'b0;
      repeat (2) tick();
      check("reset_level", 64'(level), 64'd0);
      check("reset_flags", 64'({rd_valid, busy, done, overflow}), 64'd0);
      reset = 1'b1;
      tick();

      // Mode 1: every instruction, drained as it arrives
      rd_ready = 1'b1;
      popped_pc.delete(); popped_cp.delete();
      do_start(2'd1, '0, '0);
      for (int i = 0; i < 6; i++) fetch(PC_W'(4 * i));
      tick();
      check("m1_count", 64'(popped_pc.size()), 64'd6);
      for (int i = 0; i < 6; i++) check("m1_pc", 64'(popped_pc[i]), 64'(4 * i));
      check("m1_done", 64'(done), 64'd0);
      do_stop();

      // Mode 2: branches only; a held change_pc is a single event
      popped_pc.delete(); popped_cp.delete();
      do_start(2'd2, '0, '0);
      dbg_change_pc = 1'b1; dbg_pc = 16'h10; tick();
      dbg_change_pc = 1'b0; tick();
      fetch(16'h18);
      dbg_change_pc = 1'b1; dbg_pc = 16'h20; tick(); tick();
      dbg_change_pc = 1'b0; tick();
      dbg_change_pc = 1'b1; dbg_pc = 16'h30; tick();
      dbg_change_pc = 1'b0; tick(); tick();
      check("m2_count", 64'(popped_pc.size()), 64'd3);
      check("m2_pc0", 64'(popped_pc[0]), 64'h10);
      check("m2_pc1", 64'(popped_pc[1]), 64'h20);
      check("m2_pc2", 64'(popped_pc[2]), 64'h30);
      for (int i = 0; i < 3; i++) check("m2_cp", 64'(popped_cp[i]), 64'd1);
      do_stop();

      // Mode 3: trigger at 0x0C, two more instructions, then finished
      popped_pc.delete(); popped_cp.delete();
      do_start(2'd3, 16'h0C, 8'd2);
      for (int i = 0; i < 7; i++) fetch(PC_W'(4 * i));
      tick();
      check("m3_count", 64'(popped_pc.size()), 64'd3);
      check("m3_pc0", 64'(popped_pc[0]), 64'h0C);
      check("m3_pc1", 64'(popped_pc[1]), 64'h10);
      check("m3_pc2", 64'(popped_pc[2]), 64'h14);
      check("m3_done", 64'(done), 64'd1);

      // Reset in the middle of a capture discards queued entries
      rd_ready = 1'b0;
      do_start(2'd1, '0, '0);
      for (int i = 0; i < 5; i++) fetch(PC_W'(8 * i));
      check("rst_pre_level", 64'(level), 64'd5);
      reset = 1'b0;
      repeat (3) tick();
      check("rst_level", 64'(level), 64'd0);
      check("rst_flags", 64'({rd_valid, busy, done, overflow}), 64'd0);
      reset = 1'b1;
      tick();

      // Overflow accounting and push+pop on a full FIFO
      do_start(2'd1, '0, '0);
      for (int i = 0; i < 20; i++) fetch(PC_W'(4 * i));
      check("ovf_level", 64'(level), 64'd16);
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_drops", 64'(drop_count), 64'd4);
      rd_ready = 1'b1; dbg_state = 2'd0; dbg_pc = 16'h80; tick();
      rd_ready = 1'b0; dbg_state = 2'd1; tick();
      check("full_pushpop_level", 64'(level), 64'd16);
      check("full_pushpop_drops", 64'(drop_count), 64'd4);
      do_stop();
      do_start(2'd1, '0, '0);
      check("restart_ovf", 64'(overflow), 64'd0);
      check("restart_drops", 64'(drop_count), 64'd0);
      check("restart_keeps", 64'(level), 64'd16);

      // Stop coinciding with an event: event is not stored
      rd_ready = 1'b1;
      repeat (20) tick();
      rd_ready = 1'b0;
      stop = 1'b1; dbg_state = 2'd0; dbg_pc = 16'h44; tick();
      stop = 1'b0; dbg_state = 2'd1; tick();
      check("stop_level", 64'(level), 64'd0);
      check("stop_done", 64'(done), 64'd1);
      check("stop_busy", 64'(busy), 64'd0);

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         reset         = ($urandom_range(0, 299) != 0);
         start         = ($urandom_range(0, 39) == 0);
         stop          = ($urandom_range(0, 59) == 0);
         mode          = 2'($urandom_range(0, 3));
         trig_pc       = PC_W'(4 * $urandom_range(0, 7));
         post_count    = CNT_W'($urandom_range(0, 3));
         dbg_pc        = PC_W'(4 * $urandom_range(0, 7));
         dbg_instr     = $urandom;
         dbg_state     = 2'($urandom_range(0, 3));
         dbg_change_pc = ($urandom_range(0, 2) == 0);
         rd_ready      = ($urandom_range(0, 3) == 0);
         tick();
      end
      reset = 1'b1; start = 1'b0; stop = 1'b0; rd_ready = 1'b1; dbg_state = 2'd1;
      repeat (DEPTH + 2) tick();
      check("final_empty", 64'(level), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
